// File: rtl/axis_pkt_player.sv
// AXI-Stream packet replay engine: beats are loaded into a small memory over the
// config port and replayed as packets with optional inter-packet gap and looping.
module axis_pkt_player #(
  parameter int C_M_AXIS_DATA_WIDTH  = 512,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int DEPTH_WIDTH          = 6,
  parameter int GAP_WIDTH            = 16,
  parameter int LOOP_WIDTH           = 16
) (
  input  logic                                 clk,
  input  logic                                 aresetn,
  input  logic                                 cfg_wr_en,
  input  logic [DEPTH_WIDTH-1:0]               cfg_wr_addr,
  input  logic [C_M_AXIS_DATA_WIDTH-1:0]       cfg_wr_tdata,
  input  logic [C_M_AXIS_DATA_WIDTH/8-1:0]     cfg_wr_tkeep,
  input  logic [C_M_AXIS_TUSER_WIDTH-1:0]      cfg_wr_tuser,
  input  logic                                 cfg_wr_tlast,
  input  logic [DEPTH_WIDTH:0]                 cfg_num_beats,
  input  logic [GAP_WIDTH-1:0]                 cfg_gap,
  input  logic [LOOP_WIDTH-1:0]                cfg_loops,
  input  logic                                 start,
  input  logic                                 stop,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic                                 m_axis_tlast,
  output logic                                 busy,
  output logic                                 done,
  output logic [31:0]                          pkt_count
);

  localparam int KEEP_WIDTH  = C_M_AXIS_DATA_WIDTH / 8;
  localparam int NUM_ENTRIES = 1 << DEPTH_WIDTH;

  localparam logic [DEPTH_WIDTH:0]   NB_ONE   = 1;
  localparam logic [DEPTH_WIDTH-1:0] PTR_ONE  = 1;
  localparam logic [GAP_WIDTH-1:0]   GAP_ONE  = 1;
  localparam logic [LOOP_WIDTH-1:0]  LOOP_ONE = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t                  state_reg;
  logic [DEPTH_WIDTH-1:0]  ptr_reg;
  logic [DEPTH_WIDTH:0]    num_beats_reg;
  logic [GAP_WIDTH-1:0]    gap_reg;
  logic [GAP_WIDTH-1:0]    gap_cnt_reg;
  logic [LOOP_WIDTH-1:0]   loops_reg;
  logic [LOOP_WIDTH-1:0]   loops_done_reg;
  logic                    stop_pending_reg;

  logic [C_M_AXIS_DATA_WIDTH-1:0]  mem_tdata [NUM_ENTRIES];
  logic [KEEP_WIDTH-1:0]           mem_tkeep [NUM_ENTRIES];
  logic [C_M_AXIS_TUSER_WIDTH-1:0] mem_tuser [NUM_ENTRIES];
  logic                            mem_tlast [NUM_ENTRIES];

  // Memory is frozen during replay so the running sequence stays coherent.
  always_ff @(posedge clk) begin
    if (cfg_wr_en && !busy) begin
      mem_tdata[cfg_wr_addr] <= cfg_wr_tdata;
      mem_tkeep[cfg_wr_addr] <= cfg_wr_tkeep;
      mem_tuser[cfg_wr_addr] <= cfg_wr_tuser;
      mem_tlast[cfg_wr_addr] <= cfg_wr_tlast;
    end
  end

  logic                   handshake;
  logic                   seq_end;
  logic [DEPTH_WIDTH-1:0] ptr_next;
  logic [DEPTH_WIDTH-1:0] rd_idx;
  logic [DEPTH_WIDTH:0]   rd_nb;
  logic                   rd_tlast;
  logic [LOOP_WIDTH-1:0]  loops_done_next;

  // rd_idx selects the entry that will be loaded if the FSM loads this cycle.
  always_comb begin
    handshake       = m_axis_tvalid & m_axis_tready;
    seq_end         = ({1'b0, ptr_reg} == (num_beats_reg - NB_ONE));
    ptr_next        = seq_end ? '0 : (ptr_reg + PTR_ONE);
    loops_done_next = loops_done_reg + LOOP_ONE;
    rd_idx          = ptr_reg;
    rd_nb           = num_beats_reg;
    case (state_reg)
      IDLE: begin
        rd_idx = '0;
        rd_nb  = cfg_num_beats;
      end
      SEND:    rd_idx = ptr_next;
      default: rd_idx = ptr_reg;
    endcase
    rd_tlast = mem_tlast[rd_idx] | ({1'b0, rd_idx} == (rd_nb - NB_ONE));
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_reg        <= IDLE;
      ptr_reg          <= '0;
      num_beats_reg    <= '0;
      gap_reg          <= '0;
      gap_cnt_reg      <= '0;
      loops_reg        <= '0;
      loops_done_reg   <= '0;
      stop_pending_reg <= 1'b0;
      m_axis_tdata     <= '0;
      m_axis_tkeep     <= '0;
      m_axis_tuser     <= '0;
      m_axis_tvalid    <= 1'b0;
      m_axis_tlast     <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pkt_count        <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start && (cfg_num_beats != '0)) begin
            num_beats_reg    <= cfg_num_beats;
            gap_reg          <= cfg_gap;
            loops_reg        <= cfg_loops;
            ptr_reg          <= '0;
            loops_done_reg   <= '0;
            pkt_count        <= '0;
            stop_pending_reg <= 1'b0;
            m_axis_tdata     <= mem_tdata[rd_idx];
            m_axis_tkeep     <= mem_tkeep[rd_idx];
            m_axis_tuser     <= mem_tuser[rd_idx];
            m_axis_tlast     <= rd_tlast;
            m_axis_tvalid    <= 1'b1;
            busy             <= 1'b1;
            state_reg        <= SEND;
          end
        end

        SEND: begin
          if (stop) stop_pending_reg <= 1'b1;
          if (handshake) begin
            ptr_reg <= ptr_next;
            if (m_axis_tlast) begin
              pkt_count <= pkt_count + 32'd1;
              if (seq_end) loops_done_reg <= loops_done_next;
            end
            // Completion, stop and gap only take effect on a packet boundary.
            if (m_axis_tlast && seq_end && (loops_reg != '0) && (loops_done_next == loops_reg)) begin
              m_axis_tvalid    <= 1'b0;
              busy             <= 1'b0;
              done             <= 1'b1;
              stop_pending_reg <= 1'b0;
              state_reg        <= IDLE;
            end else if (m_axis_tlast && (stop_pending_reg || stop)) begin
              m_axis_tvalid    <= 1'b0;
              busy             <= 1'b0;
              stop_pending_reg <= 1'b0;
              state_reg        <= IDLE;
            end else if (m_axis_tlast && (gap_reg != '0)) begin
              m_axis_tvalid <= 1'b0;
              gap_cnt_reg   <= gap_reg;
              state_reg     <= GAP;
            end else begin
              m_axis_tdata  <= mem_tdata[rd_idx];
              m_axis_tkeep  <= mem_tkeep[rd_idx];
              m_axis_tuser  <= mem_tuser[rd_idx];
              m_axis_tlast  <= rd_tlast;
              m_axis_tvalid <= 1'b1;
            end
          end
        end

        GAP: begin
          if (stop) begin
            busy             <= 1'b0;
            stop_pending_reg <= 1'b0;
            state_reg        <= IDLE;
          end else if (gap_cnt_reg == GAP_ONE) begin
            m_axis_tdata  <= mem_tdata[rd_idx];
            m_axis_tkeep  <= mem_tkeep[rd_idx];
            m_axis_tuser  <= mem_tuser[rd_idx];
            m_axis_tlast  <= rd_tlast;
            m_axis_tvalid <= 1'b1;
            state_reg     <= SEND;
          end else begin
            gap_cnt_reg <= gap_cnt_reg - GAP_ONE;
          end
        end

        default: begin
          m_axis_tvalid <= 1'b0;
          busy          <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_pkt_player.sv
// Directed testbench for axis_pkt_player: one task per scenario, each with its
// own hand-computed expectations.
module tb_axis_pkt_player;

  localparam int DW    = 512;
  localparam int KW    = DW / 8;
  localparam int UW    = 128;
  localparam int DEPTH = 6;
  localparam int GW    = 16;
  localparam int LW    = 16;

  logic            clk = 1'b0;
  logic            aresetn;
  logic            cfg_wr_en;
  logic [DEPTH-1:0] cfg_wr_addr;
  logic [DW-1:0]   cfg_wr_tdata;
  logic [KW-1:0]   cfg_wr_tkeep;
  logic [UW-1:0]   cfg_wr_tuser;
  logic            cfg_wr_tlast;
  logic [DEPTH:0]  cfg_num_beats;
  logic [GW-1:0]   cfg_gap;
  logic [LW-1:0]   cfg_loops;
  logic            start;
  logic            stop;
  logic [DW-1:0]   m_axis_tdata;
  logic [KW-1:0]   m_axis_tkeep;
  logic [UW-1:0]   m_axis_tuser;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic            m_axis_tlast;
  logic            busy;
  logic            done;
  logic [31:0]     pkt_count;

  int vectors = 0;
  int miscompares = 0;

  // Capture results of the most recent replay window.
  logic [DW-1:0] cap_data[$];
  logic [KW-1:0] cap_keep[$];
  logic [UW-1:0] cap_user[$];
  logic          cap_last[$];
  int            cap_cyc[$];
  int            done_cnt;
  int            done_cyc;
  int            stall_changes;
  int            valid_ones;
  bit            rdy_pat[8];
  int            rdy_len = 0;

  axis_pkt_player #(
    .C_M_AXIS_DATA_WIDTH (DW),
    .C_M_AXIS_TUSER_WIDTH(UW),
    .DEPTH_WIDTH         (DEPTH),
    .GAP_WIDTH           (GW),
    .LOOP_WIDTH          (LW)
  ) dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .cfg_wr_en    (cfg_wr_en),
    .cfg_wr_addr  (cfg_wr_addr),
    .cfg_wr_tdata (cfg_wr_tdata),
    .cfg_wr_tkeep (cfg_wr_tkeep),
    .cfg_wr_tuser (cfg_wr_tuser),
    .cfg_wr_tlast (cfg_wr_tlast),
    .cfg_num_beats(cfg_num_beats),
    .cfg_gap      (cfg_gap),
    .cfg_loops    (cfg_loops),
    .start        (start),
    .stop         (stop),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .busy         (busy),
    .done         (done),
    .pkt_count    (pkt_count)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mk_data(input int idx, input int salt);
    logic [31:0] w;
    w = (32'(salt) << 16) | 32'(idx);
    return {(DW/32){w}};
  endfunction

  function automatic logic [UW-1:0] mk_user(input int idx, input int salt);
    logic [31:0] w;
    w = ~((32'(salt) << 16) | 32'(idx));
    return {(UW/32){w}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int idx, input int salt, input logic [KW-1:0] keep,
                             input logic last);
    cfg_wr_en    = 1'b1;
    cfg_wr_addr  = DEPTH'(idx);
    cfg_wr_tdata = mk_data(idx, salt);
    cfg_wr_tkeep = keep;
    cfg_wr_tuser = mk_user(idx, salt);
    cfg_wr_tlast = last;
    tick();
    cfg_wr_en = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Records every handshake, done pulse and stall-stability violation over a window.
  task automatic capture(input int ncycles, input int stop_at);
    logic [DW-1:0] s_data;
    logic [KW-1:0] s_keep;
    logic [UW-1:0] s_user;
    logic          s_last;
    bit            stalled;
    cap_data.delete(); cap_keep.delete(); cap_user.delete();
    cap_last.delete(); cap_cyc.delete();
    done_cnt = 0; done_cyc = -1; stall_changes = 0; valid_ones = 0; stalled = 0;
    s_data = '0; s_keep = '0; s_user = '0; s_last = 1'b0;
    for (int c = 0; c < ncycles; c++) begin
      m_axis_tready = (c < rdy_len) ? rdy_pat[c] : 1'b1;
      stop = (c == stop_at);
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (m_axis_tvalid === 1'b1) valid_ones++;
      if (stalled && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== s_data ||
                      m_axis_tkeep !== s_keep || m_axis_tuser !== s_user ||
                      m_axis_tlast !== s_last))
        stall_changes++;
      stalled = 0;
      if (m_axis_tvalid === 1'b1) begin
        if (m_axis_tready) begin
          cap_data.push_back(m_axis_tdata);
          cap_keep.push_back(m_axis_tkeep);
          cap_user.push_back(m_axis_tuser);
          cap_last.push_back(m_axis_tlast);
          cap_cyc.push_back(c);
          $display("beat cyc=%0d last=%0b keep=%h data_lo=%h", c, m_axis_tlast,
                   m_axis_tkeep[7:0], m_axis_tdata[31:0]);
        end else begin
          stalled = 1;
          s_data = m_axis_tdata; s_keep = m_axis_tkeep;
          s_user = m_axis_tuser; s_last = m_axis_tlast;
        end
      end
      tick();
    end
    stop = 1'b0;
    m_axis_tready = 1'b1;
    rdy_len = 0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    tick(); tick();
    vectors++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || m_axis_tlast !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got valid=%b busy=%b done=%b last=%b exp 0 0 0 0",
               m_axis_tvalid, busy, done, m_axis_tlast);
    end
    vectors++;
    if (pkt_count !== 32'd0 || m_axis_tdata !== '0 || m_axis_tkeep !== '0 || m_axis_tuser !== '0) begin
      miscompares++;
      $display("FAIL reset_data got pkt_count=%0d data_lo=%h keep_lo=%h exp all zero",
               pkt_count, m_axis_tdata[31:0], m_axis_tkeep[7:0]);
    end
    aresetn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    write_entry(0, 1, {KW{1'b1}}, 1'b0);
    write_entry(1, 1, 64'h3, 1'b1);
    cfg_num_beats = 7'd2; cfg_gap = '0; cfg_loops = 16'd1;
    do_start();
    capture(6, -1);
    vectors++;
    if (cap_data.size() != 2) begin
      miscompares++;
      $display("FAIL basic_beats got %0d exp 2", cap_data.size());
    end else begin
      vectors++;
      if (cap_cyc[0] != 0 || cap_cyc[1] != 1) begin
        miscompares++;
        $display("FAIL basic_timing got cyc %0d,%0d exp 0,1", cap_cyc[0], cap_cyc[1]);
      end
      vectors++;
      if (cap_data[0] !== mk_data(0, 1) || cap_data[1] !== mk_data(1, 1) ||
          cap_user[1] !== mk_user(1, 1)) begin
        miscompares++;
        $display("FAIL basic_data got %h,%h exp %h,%h", cap_data[0][31:0], cap_data[1][31:0],
                 mk_data(0, 1) & 512'hFFFFFFFF, mk_data(1, 1) & 512'hFFFFFFFF);
      end
      vectors++;
      if (cap_last[0] !== 1'b0 || cap_last[1] !== 1'b1 || cap_keep[0] !== {KW{1'b1}} ||
          cap_keep[1] !== 64'h3) begin
        miscompares++;
        $display("FAIL basic_last_keep got last=%b%b keep1=%h exp last=01 keep1=3",
                 cap_last[0], cap_last[1], cap_keep[1]);
      end
    end
    vectors++;
    if (done_cnt != 1 || done_cyc != 2) begin
      miscompares++;
      $display("FAIL basic_done got cnt=%0d cyc=%0d exp cnt=1 cyc=2", done_cnt, done_cyc);
    end
    vectors++;
    if (pkt_count !== 32'd1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_status got pkt_count=%0d busy=%b exp 1 0", pkt_count, busy);
    end
  endtask

  task automatic test_backpressure();
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    rdy_len = 4;
    do_start();
    capture(7, -1);
    vectors++;
    if (stall_changes != 0) begin
      miscompares++;
      $display("FAIL bp_stable got %0d changes during stall exp 0", stall_changes);
    end
    vectors++;
    if (cap_data.size() != 2) begin
      miscompares++;
      $display("FAIL bp_beats got %0d exp 2", cap_data.size());
    end else begin
      vectors++;
      if (cap_data[0] !== mk_data(0, 1) || cap_data[1] !== mk_data(1, 1) || cap_cyc[1] != 3) begin
        miscompares++;
        $display("FAIL bp_order got %h@%0d,%h@%0d exp %h@0,%h@3", cap_data[0][31:0], cap_cyc[0],
                 cap_data[1][31:0], cap_cyc[1], 32'h00010000, 32'h00010001);
      end
    end
    vectors++;
    if (done_cnt != 1 || pkt_count !== 32'd1) begin
      miscompares++;
      $display("FAIL bp_done got done_cnt=%0d pkt_count=%0d exp 1 1", done_cnt, pkt_count);
    end
  endtask

  task automatic test_gap_loops();
    for (int i = 0; i < 4; i++) write_entry(i, 3, {KW{1'b1}}, 1'b1);
    cfg_num_beats = 7'd4; cfg_gap = 16'd3; cfg_loops = 16'd2;
    do_start();
    capture(36, -1);
    vectors++;
    if (cap_data.size() != 8) begin
      miscompares++;
      $display("FAIL gap_pkts got %0d exp 8", cap_data.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        vectors++;
        if (cap_cyc[k] != 4 * k || cap_data[k] !== mk_data(k % 4, 3) || cap_last[k] !== 1'b1) begin
          miscompares++;
          $display("FAIL gap_pkt%0d got cyc=%0d data=%h exp cyc=%0d data=%h", k, cap_cyc[k],
                   cap_data[k][31:0], 4 * k, 32'h00030000 | (k % 4));
        end
      end
    end
    vectors++;
    if (valid_ones != 8 || done_cnt != 1 || done_cyc != 29) begin
      miscompares++;
      $display("FAIL gap_done got valid=%0d done_cnt=%0d done_cyc=%0d exp 8 1 29",
               valid_ones, done_cnt, done_cyc);
    end
    vectors++;
    if (pkt_count !== 32'd8 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL gap_status got pkt_count=%0d busy=%b exp 8 0", pkt_count, busy);
    end
  endtask

  task automatic test_forced_tlast();
    for (int i = 0; i < 3; i++) write_entry(i, 4, {KW{1'b1}}, 1'b0);
    cfg_num_beats = 7'd3; cfg_gap = '0; cfg_loops = 16'd1;
    do_start();
    capture(7, -1);
    vectors++;
    if (cap_data.size() != 3) begin
      miscompares++;
      $display("FAIL forced_beats got %0d exp 3", cap_data.size());
    end else begin
      vectors++;
      if (cap_last[0] !== 1'b0 || cap_last[1] !== 1'b0 || cap_last[2] !== 1'b1 ||
          cap_data[2] !== mk_data(2, 4)) begin
        miscompares++;
        $display("FAIL forced_last got %b%b%b exp 001", cap_last[0], cap_last[1], cap_last[2]);
      end
    end
    vectors++;
    if (pkt_count !== 32'd1 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL forced_count got pkt_count=%0d done=%0d exp 1 1", pkt_count, done_cnt);
    end
  endtask

  task automatic test_stop();
    cfg_num_beats = 7'd3; cfg_gap = '0; cfg_loops = 16'd0;
    do_start();
    capture(9, 1);
    vectors++;
    if (cap_data.size() != 3 || valid_ones != 3) begin
      miscompares++;
      $display("FAIL stop_beats got %0d handshakes %0d valid exp 3 3", cap_data.size(), valid_ones);
    end else begin
      vectors++;
      if (cap_data[1] !== mk_data(1, 4) || cap_data[2] !== mk_data(2, 4) || cap_last[2] !== 1'b1) begin
        miscompares++;
        $display("FAIL stop_tail got %h,%h last=%b exp %h,%h last=1", cap_data[1][31:0],
                 cap_data[2][31:0], cap_last[2], 32'h00040001, 32'h00040002);
      end
    end
    vectors++;
    if (done_cnt != 0 || busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL stop_idle got done_cnt=%0d busy=%b valid=%b exp 0 0 0",
               done_cnt, busy, m_axis_tvalid);
    end
  endtask

  task automatic test_reset_mid_packet();
    cfg_num_beats = 7'd3; cfg_gap = '0; cfg_loops = 16'd0;
    do_start();
    tick();
    vectors++;
    if (m_axis_tvalid !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_pre got valid=%b busy=%b exp 1 1", m_axis_tvalid, busy);
    end
    aresetn = 1'b0;
    tick();
    vectors++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || pkt_count !== 32'd0) begin
      miscompares++;
      $display("FAIL midrst_post got valid=%b busy=%b pkt_count=%0d exp 0 0 0",
               m_axis_tvalid, busy, pkt_count);
    end
    aresetn = 1'b1;
    repeat (4) tick();
    vectors++;
    if (m_axis_tvalid !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_after got valid=%b done=%b exp 0 0", m_axis_tvalid, done);
    end
  endtask

  task automatic test_zero_beats();
    cfg_num_beats = 7'd0; cfg_gap = '0; cfg_loops = 16'd1;
    do_start();
    vectors++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_start got valid=%b busy=%b exp 0 0", m_axis_tvalid, busy);
    end
    tick();
    vectors++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_later got valid=%b busy=%b done=%b exp 0 0 0", m_axis_tvalid, busy, done);
    end
  endtask

  task automatic test_write_while_busy();
    int waited;
    for (int i = 0; i < 3; i++) write_entry(i, 8, {KW{1'b1}}, 1'b0);
    cfg_num_beats = 7'd3; cfg_gap = 16'd2; cfg_loops = 16'd0;
    do_start();
    write_entry(1, 9, 64'h5, 1'b1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    waited = 0;
    while (busy === 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL wrbusy_stop got busy=%b after %0d cycles exp 0", busy, waited);
    end
    cfg_gap = '0; cfg_loops = 16'd1;
    do_start();
    capture(7, -1);
    vectors++;
    if (cap_data.size() != 3) begin
      miscompares++;
      $display("FAIL wrbusy_beats got %0d exp 3", cap_data.size());
    end else begin
      vectors++;
      if (cap_data[1] !== mk_data(1, 8) || cap_keep[1] !== {KW{1'b1}} || cap_last[1] !== 1'b0) begin
        miscompares++;
        $display("FAIL wrbusy_mem got %h keep_lo=%h last=%b exp %h keep_lo=ff last=0",
                 cap_data[1][31:0], cap_keep[1][7:0], cap_last[1], 32'h00080001);
      end
    end
  endtask

  initial begin
    aresetn = 1'b0; cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_tdata = '0;
    cfg_wr_tkeep = '0; cfg_wr_tuser = '0; cfg_wr_tlast = 1'b0;
    cfg_num_beats = '0; cfg_gap = '0; cfg_loops = '0;
    start = 1'b0; stop = 1'b0; m_axis_tready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_gap_loops();
    test_forced_tlast();
    test_stop();
    test_reset_mid_packet();
    test_zero_beats();
    test_write_while_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t exp run to completion", $time);
    $fatal(1, "timeout");
  end

endmodule
